// File: rtl/apuracao_votos.sv
// Post-election tally readout: snapshots the five totals on finish, picks the
// winning candidate over four compare cycles and streams an 8-byte result frame.
module apuracao_votos #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       finish,
  input  logic [7:0] totalvotos_matheus,
  input  logic [7:0] totalvotos_luis,
  input  logic [7:0] totalvotos_vinicius,
  input  logic [7:0] totalvotos_random,
  input  logic [7:0] totalvotos_nulos,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner,
  output logic       tie
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    SEND    = 2'd2
  } state_t;

  function automatic logic [7:0] frame_checksum(
    input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
    input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
    input logic [7:0] b6
  );
    return b0 ^ b1 ^ b2 ^ b3 ^ b4 ^ b5 ^ b6;
  endfunction

  state_t     state_r, state_s;
  logic [7:0] snap_m_r, snap_l_r, snap_v_r, snap_rnd_r, snap_n_r;
  logic [7:0] snap_m_s, snap_l_s, snap_v_s, snap_rnd_s, snap_n_s;
  logic [1:0] cmp_idx_r, cmp_idx_s;
  logic [7:0] max_r, max_s;
  logic [1:0] max_idx_r, max_idx_s;
  logic       run_tie_r, run_tie_s;
  logic [2:0] byte_idx_r, byte_idx_s;
  logic [7:0] checksum_r, checksum_s;
  logic [7:0] tx_data_r, tx_data_s;
  logic       tx_valid_r, tx_valid_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;
  logic [1:0] winner_r, winner_s;
  logic       tie_r, tie_s;

  logic [7:0] cand_s;
  logic [7:0] next_byte_s;
  logic [2:0] next_idx_s;
  logic       accept_s;

  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign winner   = winner_r;
  assign tie      = tie_r;

  assign accept_s   = tx_valid_r & tx_ready;
  assign next_idx_s = byte_idx_r + 3'd1;

  // Candidate examined in the current compare cycle (nulos never compete).
  always_comb begin
    cand_s = 8'd0;
    case (cmp_idx_r)
      2'd0:    cand_s = snap_m_r;
      2'd1:    cand_s = snap_l_r;
      2'd2:    cand_s = snap_v_r;
      2'd3:    cand_s = snap_rnd_r;
      default: cand_s = 8'd0;
    endcase
  end

  // Frame byte presented after the current one is accepted.
  always_comb begin
    next_byte_s = 8'd0;
    case (next_idx_s)
      3'd0:    next_byte_s = HEADER;
      3'd1:    next_byte_s = snap_m_r;
      3'd2:    next_byte_s = snap_l_r;
      3'd3:    next_byte_s = snap_v_r;
      3'd4:    next_byte_s = snap_rnd_r;
      3'd5:    next_byte_s = snap_n_r;
      3'd6:    next_byte_s = {tie_r, 5'b00000, winner_r};
      3'd7:    next_byte_s = checksum_r;
      default: next_byte_s = 8'd0;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s    = state_r;
    snap_m_s   = snap_m_r;
    snap_l_s   = snap_l_r;
    snap_v_s   = snap_v_r;
    snap_rnd_s = snap_rnd_r;
    snap_n_s   = snap_n_r;
    cmp_idx_s  = cmp_idx_r;
    max_s      = max_r;
    max_idx_s  = max_idx_r;
    run_tie_s  = run_tie_r;
    byte_idx_s = byte_idx_r;
    checksum_s = checksum_r;
    tx_data_s  = tx_data_r;
    tx_valid_s = tx_valid_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    winner_s   = winner_r;
    tie_s      = tie_r;

    case (state_r)
      IDLE: begin
        if (finish) begin
          // The counter clears on the next edge, so capture happens now.
          snap_m_s   = totalvotos_matheus;
          snap_l_s   = totalvotos_luis;
          snap_v_s   = totalvotos_vinicius;
          snap_rnd_s = totalvotos_random;
          snap_n_s   = totalvotos_nulos;
          cmp_idx_s  = 2'd0;
          busy_s     = 1'b1;
          state_s    = COMPARE;
        end else begin
          state_s = IDLE;
        end
      end

      COMPARE: begin
        if (cmp_idx_r == 2'd0) begin
          max_s     = cand_s;
          max_idx_s = 2'd0;
          run_tie_s = 1'b0;
        end else if (cand_s > max_r) begin
          max_s     = cand_s;
          max_idx_s = cmp_idx_r;
          run_tie_s = 1'b0;
        end else if (cand_s == max_r) begin
          run_tie_s = 1'b1;
        end else begin
          run_tie_s = run_tie_r;
        end

        if (cmp_idx_r == 2'd3) begin
          winner_s   = max_idx_s;
          tie_s      = run_tie_s;
          checksum_s = frame_checksum(HEADER, snap_m_r, snap_l_r, snap_v_r,
                                      snap_rnd_r, snap_n_r,
                                      {run_tie_s, 5'b00000, max_idx_s});
          byte_idx_s = 3'd0;
          tx_data_s  = HEADER;
          tx_valid_s = 1'b1;
          state_s    = SEND;
        end else begin
          cmp_idx_s = cmp_idx_r + 2'd1;
        end
      end

      SEND: begin
        if (accept_s) begin
          if (byte_idx_r == 3'd7) begin
            byte_idx_s = 3'd0;
            tx_data_s  = 8'd0;
            tx_valid_s = 1'b0;
            busy_s     = 1'b0;
            done_s     = 1'b1;
            state_s    = IDLE;
          end else begin
            byte_idx_s = next_idx_s;
            tx_data_s  = next_byte_s;
          end
        end else begin
          tx_data_s = tx_data_r;
        end
      end

      default: begin
        state_s    = IDLE;
        tx_valid_s = 1'b0;
        busy_s     = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      snap_m_r   <= 8'd0;
      snap_l_r   <= 8'd0;
      snap_v_r   <= 8'd0;
      snap_rnd_r <= 8'd0;
      snap_n_r   <= 8'd0;
      cmp_idx_r  <= 2'd0;
      max_r      <= 8'd0;
      max_idx_r  <= 2'd0;
      run_tie_r  <= 1'b0;
      byte_idx_r <= 3'd0;
      checksum_r <= 8'd0;
      tx_data_r  <= 8'd0;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      winner_r   <= 2'd0;
      tie_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      snap_m_r   <= snap_m_s;
      snap_l_r   <= snap_l_s;
      snap_v_r   <= snap_v_s;
      snap_rnd_r <= snap_rnd_s;
      snap_n_r   <= snap_n_s;
      cmp_idx_r  <= cmp_idx_s;
      max_r      <= max_s;
      max_idx_r  <= max_idx_s;
      run_tie_r  <= run_tie_s;
      byte_idx_r <= byte_idx_s;
      checksum_r <= checksum_s;
      tx_data_r  <= tx_data_s;
      tx_valid_r <= tx_valid_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      winner_r   <= winner_s;
      tie_r      <= tie_s;
    end
  end

endmodule
